// File: rtl/divu_seq_unit.sv
// Sequential restoring divider producing one quotient bit per cycle; result = {remainder, quotient}.
// Define DIVU_SIGNED_EN to add DIV (signed) support selected by is_signed.
module divu_seq_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [63:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        dz_q, dz_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        div_zero_q, div_zero_d;
   logic [63:0] result_q, result_d;

   logic [32:0] rem_sh;
   logic [32:0] trial;
   logic [31:0] nxt_rem;
   logic [31:0] nxt_quo;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

`ifdef DIVU_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;
   logic a_neg;
   logic b_neg;

   assign a_neg = is_signed & dividend[31];
   assign b_neg = is_signed & divisor[31];
   assign a_mag = a_neg ? -dividend : dividend;
   assign b_mag = b_neg ? -divisor : divisor;
   // A zero divisor keeps the all-ones quotient; the remainder negation restores the raw dividend.
   assign q_fix = neg_quo_q ? -nxt_quo : nxt_quo;
   assign r_fix = neg_rem_q ? -nxt_rem : nxt_rem;
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign a_mag = dividend;
   assign b_mag = divisor;
   assign q_fix = nxt_quo;
   assign r_fix = nxt_rem;
`endif

   // The partial remainder is always below the divisor, so only the shifted value needs bit 32.
   assign rem_sh  = {rem_q, quo_q[31]};
   assign trial   = rem_sh - {1'b0, dvsr_q};
   assign nxt_rem = trial[32] ? rem_sh[31:0] : trial[31:0];
   assign nxt_quo = {quo_q[30:0], ~trial[32]};

   // NOTE: every signal assigned below gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvsr_d     = dvsr_q;
      cnt_d      = cnt_q;
      dz_d       = dz_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      result_d   = result_q;
`ifdef DIVU_SIGNED_EN
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d   = S_RUN;
               busy_d    = 1'b1;
               rem_d     = 32'h0;
               quo_d     = a_mag;
               dvsr_d    = b_mag;
               cnt_d     = 5'd0;
               dz_d      = (divisor == 32'h0);
`ifdef DIVU_SIGNED_EN
               neg_quo_d = (a_neg ^ b_neg) & (divisor != 32'h0);
               neg_rem_d = a_neg;
`endif
            end
         end
         S_RUN: begin
            busy_d = 1'b1;
            rem_d  = nxt_rem;
            quo_d  = nxt_quo;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d    = S_DONE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               result_d   = {r_fix, q_fix};
               div_zero_d = dz_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rem_q      <= 32'h0;
         quo_q      <= 32'h0;
         dvsr_q     <= 32'h0;
         cnt_q      <= 5'd0;
         dz_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         result_q   <= 64'h0;
`ifdef DIVU_SIGNED_EN
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvsr_q     <= dvsr_d;
         cnt_q      <= cnt_d;
         dz_q       <= dz_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         result_q   <= result_d;
`ifdef DIVU_SIGNED_EN
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign result   = result_q;

endmodule
